// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction-fetch stage. Owns the program counter, drives the
//               byte address into a combinational instruction memory, captures
//               each {pc, instr} pair into a small in-order buffer and hands it
//               to decode over a valid/ready handshake. Redirects from execute
//               flush the buffer. A misaligned redirect target parks fetch in
//               HALT until an aligned redirect arrives.
// Optional    : IFETCH_PERF_CNT_EN adds the perf_fetch_cnt and perf_stall_cnt
//               outputs and their counters.
// Ports       : clk, rst_n (async, active low)
//               imem_addr  -> instruction memory byte address (current PC)
//               imem_instr <- instruction word for imem_addr (same cycle)
//               redirect_valid/redirect_pc <- PC change request from execute
//               out_valid/out_ready/out_pc/out_instr -> decode handshake
//               fetch_misaligned -> fetch halted on a misaligned target
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic        fetch_misaligned
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(BUF_DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_next;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_next;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] w_head_next;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] w_tail_next;
    logic             w_push;
    logic             w_pop;
    logic             w_head_is_new;

    logic [31:0]      r_buf_pc    [BUF_DEPTH];
    logic [31:0]      r_buf_instr [BUF_DEPTH];

    logic [31:0]      r_out_pc;
    logic [31:0]      r_out_instr;
    logic [31:0]      w_out_pc_next;
    logic [31:0]      w_out_instr_next;

    // ------------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------------
    always_comb begin
        w_pop            = (r_count != '0) && out_ready;
        w_push           = 1'b0;
        w_head_is_new    = 1'b0;
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_count_next     = r_count;
        w_head_next      = r_head;
        w_tail_next      = r_tail;
        w_out_pc_next    = r_out_pc;
        w_out_instr_next = r_out_instr;

        if (redirect_valid) begin
            // Redirect wins over everything: flush, void any pop, retarget.
            w_state_next = (redirect_pc[1:0] == 2'b00) ? FETCH : HALT;
            w_pc_next    = redirect_pc;
            w_count_next = '0;
            w_head_next  = '0;
            w_tail_next  = '0;
        end else begin
            w_push = (r_state == FETCH) && ((r_count < c_depth) || w_pop);

            if (w_push) begin
                w_pc_next   = r_pc + 32'd4;
                w_tail_next = r_tail + c_ptr_one;
            end
            if (w_pop) begin
                w_head_next = r_head + c_ptr_one;
            end

            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + c_cnt_one;
                2'b01:   w_count_next = r_count - c_cnt_one;
                default: w_count_next = r_count;
            endcase

            // The registered head copy must track whichever entry becomes the
            // head next cycle. If the buffer is left empty apart from the entry
            // being pushed now, that entry is not in storage yet, so it comes
            // straight from the fetch path into the head register.
            w_head_is_new = w_push && (w_pop ? (r_count == c_cnt_one)
                                             : (r_count == '0));
            if (w_head_is_new) begin
                w_out_pc_next    = r_pc;
                w_out_instr_next = imem_instr;
            end else if (w_count_next != '0) begin
                w_out_pc_next    = r_buf_pc[w_head_next];
                w_out_instr_next = r_buf_instr[w_head_next];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_out_pc    <= 32'h0;
            r_out_instr <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_count     <= w_count_next;
            r_head      <= w_head_next;
            r_tail      <= w_tail_next;
            r_out_pc    <= w_out_pc_next;
            r_out_instr <= w_out_instr_next;
        end
    end

    // ------------------------------------------------------------------------
    // Buffer storage. Contents are only ever read behind a valid count, so the
    // array itself needs no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_tail]    <= r_pc;
            r_buf_instr[r_tail] <= imem_instr;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters; they survive redirects and wrap freely.
    // ------------------------------------------------------------------------
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == FETCH) && !w_push && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_push) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_addr        = r_pc;
    assign out_valid        = (r_count != '0);
    assign out_pc           = r_out_pc;
    assign out_instr        = r_out_instr;
    assign fetch_misaligned = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit. A queue-based reference
//               model tracks the fetch stream; directed steps cover reset,
//               back-pressure, flushes, misaligned halts, PC wrap and
//               asynchronous reset, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_wrap_pc  = 32'hFFFF_FFF8;
    localparam int          c_depth    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_misaligned;

    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_instr;
    logic        w_out_valid;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_instr;
    logic        w_fetch_misaligned;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] w_perf_fetch_cnt;
    logic [31:0] w_perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    // Instruction memory: a fixed address-dependent pattern.
    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    assign imem_instr   = imem_fn(imem_addr);
    assign w_imem_instr = imem_fn(w_imem_addr);

    ifetch_unit #(.RESET_PC(c_reset_pc), .BUF_DEPTH(c_depth)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (imem_addr),
        .imem_instr       (imem_instr),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_stall_cnt   (perf_stall_cnt),
`endif
        .fetch_misaligned (fetch_misaligned)
    );

    ifetch_unit #(.RESET_PC(c_wrap_pc), .BUF_DEPTH(c_depth)) u_wrap (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr        (w_imem_addr),
        .imem_instr       (w_imem_instr),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (w_out_valid),
        .out_ready        (out_ready),
        .out_pc           (w_out_pc),
        .out_instr        (w_out_instr),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetch_cnt   (w_perf_fetch_cnt),
        .perf_stall_cnt   (w_perf_stall_cnt),
`endif
        .fetch_misaligned (w_fetch_misaligned)
    );

    // ------------------------------------------------------------------------
    // Reference model: a queue of fetched entries plus PC and halt flag.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_halt;
    logic [31:0] m_out_pc;
    logic [31:0] m_out_instr;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc        = c_reset_pc;
        m_halt      = 1'b0;
        m_out_pc    = 32'h0;
        m_out_instr = 32'h0;
        m_fetch     = 32'h0;
        m_stall     = 32'h0;
    endtask

    task automatic model_update(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic pop;
        logic push;
        pop = (m_q.size() != 0) && rdy;
        if (rv) begin
            m_q.delete();
            m_pc   = rpc;
            m_halt = (rpc[1:0] != 2'b00);
        end else begin
            push = !m_halt && ((m_q.size() < c_depth) || pop);
            if (!m_halt && !push) m_stall = m_stall + 32'd1;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back({m_pc, imem_fn(m_pc)});
                m_pc    = m_pc + 32'd4;
                m_fetch = m_fetch + 32'd1;
            end
            if (m_q.size() != 0) begin
                m_out_pc    = m_q[0].pc;
                m_out_instr = m_q[0].instr;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("misaligned", 32'(fetch_misaligned), 32'(m_halt));
        chk("out_pc", out_pc, m_out_pc);
        chk("out_instr", out_instr, m_out_instr);
`ifdef IFETCH_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    endtask

    // One clock: drive inputs (at a falling edge), advance the model across
    // the rising edge, then compare at the next falling edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_update(rdy, rv, rpc);
        @(negedge clk);
        check_all();
    endtask

    // Reset asserted between clock edges must clear state immediately.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_misaligned", 32'(fetch_misaligned), 32'h0);
        chk("arst_imem_addr", imem_addr, c_reset_pc);
        model_reset();
        @(negedge clk);
        check_all();
        redirect_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Free-running fetch with decode always ready.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

        // Back-pressure until full, then drain in order.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect while full.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Misaligned target halts fetch; aligned redirect resumes.
        step(1'b1, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0106);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a pop attempt.
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0300);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        rdy;
            logic        rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            step(rdy, rv, rpc);
        end
        step(1'b1, 1'b1, 32'h0000_0040);

        // Async reset with two entries buffered, then restart and wrap check.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        async_reset();
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("wrap_valid", 32'(w_out_valid), 32'h1);
            chk("wrap_out_pc", w_out_pc, wrap_exp[i]);
            chk("wrap_out_instr", w_out_instr, imem_fn(wrap_exp[i]));
        end

        // Async reset while halted on a misaligned target.
        step(1'b1, 1'b1, 32'h0000_0081);
        step(1'b1, 1'b0, 32'h0);
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
